// File: rtl/mem_bus_ctrl_pkg.sv
// Shared types and widths for the memory bus controller slice.
// Optional feature macro: MEM_BUS_CTRL_BYTE_EN_EN (per-lane write enables).
package mem_bus_ctrl_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned BE_W   = 4;
    localparam int unsigned CNT_W  = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

endpackage

// File: rtl/mem_word_array.sv
// Single-port word array: per-lane synchronous write, registered read.
module mem_word_array
    import mem_bus_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH = 256,
    parameter int unsigned IDX_W = 8
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [BE_W-1:0]   laneWe,
    input  logic [IDX_W-1:0]  addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // One access per enabled edge: lane-masked write or registered read.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int unsigned i = 0; i < BE_W; i++) begin
                    if (laneWe[i]) begin
                        mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
                    end
                end
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/mem_bus_ctrl.sv
// CPU MEM-stage memory controller: request latch, fault check, wait-state
// counter and IDLE/ACCESS/RESP FSM in front of mem_word_array.
// Optional feature macro: MEM_BUS_CTRL_BYTE_EN_EN (honour req_be on writes;
// when undefined every write updates the full word).
module mem_bus_ctrl
    import mem_bus_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH       = 256,
    parameter int unsigned WAIT_STATES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [BE_W-1:0]   req_be,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err
);

    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    state_t              stateQ;
    state_t              stateD;
    logic [CNT_W-1:0]    cntQ;
    logic                readyEnQ;
    logic                weQ;
    logic                errQ;
    logic [IDX_W-1:0]    idxQ;
    logic [DATA_W-1:0]   wdataQ;
    logic [BE_W-1:0]     beQ;
    logic                accept;
    logic                fault;
    logic                memEn;
    logic [BE_W-1:0]     laneWe;
    logic [DATA_W-1:0]   memRdata;

    assign accept    = req_valid && req_ready;
    assign fault     = (req_addr[1:0] != 2'b00) ||
                       ({2'b00, req_addr[ADDR_W-1:2]} >= DEPTH);
    // readyEnQ keeps req_ready low until the first edge after reset release.
    assign req_ready = readyEnQ && (stateQ == IDLE);

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stateQ <= IDLE;
        end else begin
            stateQ <= stateD;
        end
    end

    // Next-state logic: faults skip ACCESS, ACCESS exits when the counter is spent.
    always_comb begin
        stateD = stateQ;
        case (stateQ)
            IDLE: begin
                if (accept) begin
                    stateD = fault ? RESP : ACCESS;
                end
            end
            ACCESS: begin
                if (cntQ == '0) begin
                    stateD = RESP;
                end
            end
            RESP:    stateD = IDLE;
            default: stateD = IDLE;
        endcase
    end

    // Request latches, fault flag and wait-state counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            readyEnQ <= 1'b0;
            cntQ     <= '0;
            weQ      <= 1'b0;
            errQ     <= 1'b0;
            idxQ     <= '0;
            wdataQ   <= '0;
            beQ      <= '0;
        end else begin
            readyEnQ <= 1'b1;
            if (accept) begin
                weQ    <= req_we;
                errQ   <= fault;
                idxQ   <= req_addr[IDX_W+1:2];
                wdataQ <= req_wdata;
                beQ    <= req_be;
                cntQ   <= fault ? '0 : CNT_W'(WAIT_STATES);
            end else if ((stateQ == ACCESS) && (cntQ != '0)) begin
                cntQ <= cntQ - CNT_W'(1);
            end
        end
    end

`ifdef MEM_BUS_CTRL_BYTE_EN_EN
    assign laneWe = beQ;
`else
    logic unusedBe;
    assign unusedBe = ^beQ;
    assign laneWe   = '1;
`endif

    // Array access happens only on the edge that leaves ACCESS; it is
    // combinational on stateQ so an asynchronous reset cancels it.
    assign memEn = (stateQ == ACCESS) && (cntQ == '0);

    mem_word_array #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_array (
        .clk    (clk),
        .en     (memEn),
        .we     (weQ),
        .laneWe (laneWe),
        .addr   (idxQ),
        .wdata  (wdataQ),
        .rdata  (memRdata)
    );

    assign rsp_valid = (stateQ == RESP);
    assign rsp_err   = rsp_valid && errQ;
    assign rsp_rdata = (rsp_valid && !errQ && !weQ) ? memRdata : '0;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Self-checking bench for mem_bus_ctrl against a word-array reference model.
module tb_mem_bus_ctrl;

    localparam int DEPTH = 256;
    localparam int WS    = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        reqValid;
    logic        reqValid0;
    logic        reqWe;
    logic [31:0] reqAddr;
    logic [31:0] reqWdata;
    logic [3:0]  reqBe;
    logic        ready2, rspValid2, err2;
    logic [31:0] rdata2;
    logic        ready0, rspValid0, err0;
    logic [31:0] rdata0;

    int checks   = 0;
    int failures = 0;

    logic [31:0] model  [DEPTH];
    logic [31:0] model0 [DEPTH];

    always #5 clk = ~clk;

    mem_bus_ctrl #(.DEPTH(DEPTH), .WAIT_STATES(WS)) dut (
        .clk(clk), .reset(reset), .req_valid(reqValid), .req_ready(ready2),
        .req_we(reqWe), .req_addr(reqAddr), .req_wdata(reqWdata), .req_be(reqBe),
        .rsp_valid(rspValid2), .rsp_rdata(rdata2), .rsp_err(err2)
    );

    mem_bus_ctrl #(.DEPTH(DEPTH), .WAIT_STATES(0)) dut0 (
        .clk(clk), .reset(reset), .req_valid(reqValid0), .req_ready(ready0),
        .req_we(reqWe), .req_addr(reqAddr), .req_wdata(reqWdata), .req_be(reqBe),
        .rsp_valid(rspValid0), .rsp_rdata(rdata0), .rsp_err(err0)
    );

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic bit isFault(input logic [31:0] addr);
        return (addr[1:0] != 2'b00) || ((addr >> 2) >= DEPTH);
    endfunction

    function automatic logic [31:0] mergeWord(input logic [31:0] oldW, input logic [31:0] newW,
                                              input logic [3:0] be);
        logic [31:0] r;
        r = newW;
`ifdef MEM_BUS_CTRL_BYTE_EN_EN
        for (int i = 0; i < 4; i++) begin
            r[i*8 +: 8] = be[i] ? newW[i*8 +: 8] : oldW[i*8 +: 8];
        end
`endif
        return r;
    endfunction

    // Present one request (call right after a negedge) and wait for its response.
    task automatic doReq(input bit z, input bit we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] be,
                         output logic [31:0] rdata, output bit err, output int lat,
                         output bit ok);
        bit seen;
        reqWe = we; reqAddr = addr; reqWdata = wdata; reqBe = be;
        if (z) reqValid0 = 1'b1; else reqValid = 1'b1;
        ok = 1'b0; seen = 1'b0; lat = -1; rdata = '0; err = 1'b0;
        for (int c = 0; c < 50; c++) begin
            if ((z ? ready0 : ready2) === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        reqValid = 1'b0; reqValid0 = 1'b0;
        if (ok) begin
            for (int c = 0; c < 50; c++) begin
                if ((z ? rspValid0 : rspValid2) === 1'b1) begin
                    seen  = 1'b1;
                    lat   = c;
                    rdata = z ? rdata0 : rdata2;
                    err   = z ? err0 : err2;
                    break;
                end
                @(negedge clk);
            end
            if (seen) begin
                @(negedge clk);
                checkVal("pulse_width", z ? rspValid0 : rspValid2, 1'b0);
            end
        end
    endtask

    // Issue a request, compare against the model, then update the model.
    task automatic issue(input bit z, input bit we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] be,
                         output logic [31:0] rdata);
        logic [31:0] got, expData;
        bit err, ok, f;
        int lat, idx;
        f = isFault(addr);
        idx = f ? 0 : int'(addr >> 2);
        expData = z ? model0[idx] : model[idx];
        doReq(z, we, addr, wdata, be, got, err, lat, ok);
        checkVal("accept", ok, 1'b1);
        checkVal("err", err, f);
        checkVal("latency", lat, f ? 0 : (z ? 1 : WS + 1));
        if (f || !we) checkVal("rdata", got, f ? 32'h0 : expData);
        if (!f && we) begin
            if (z) model0[idx] = mergeWord(model0[idx], wdata, be);
            else   model[idx]  = mergeWord(model[idx], wdata, be);
        end
        rdata = got;
    endtask

    task automatic backToBack();
        logic        bWe   [4];
        logic [31:0] bAddr [4];
        logic [31:0] bData [4];
        logic [3:0]  bBe   [4];
        logic [31:0] expD  [4];
        int i, accCnt, pulses, viol;
        bit accPrev;
        bWe[0] = 1; bAddr[0] = 32'hC;  bData[0] = $urandom; bBe[0] = 4'hF;
        bWe[1] = 0; bAddr[1] = 32'hC;  bData[1] = '0;       bBe[1] = 4'hF;
        bWe[2] = 1; bAddr[2] = 32'h10; bData[2] = $urandom; bBe[2] = 4'($urandom);
        bWe[3] = 0; bAddr[3] = 32'h10; bData[3] = '0;       bBe[3] = 4'hF;
        for (int k = 0; k < 4; k++) begin
            if (bWe[k]) model[bAddr[k] >> 2] = mergeWord(model[bAddr[k] >> 2], bData[k], bBe[k]);
            expD[k] = model[bAddr[k] >> 2];
        end
        i = 0; accCnt = 0; pulses = 0; viol = 0;
        reqWe = bWe[0]; reqAddr = bAddr[0]; reqWdata = bData[0]; reqBe = bBe[0];
        reqValid = 1'b1;
        accPrev = ready2;
        for (int c = 0; c < 80 && pulses < 4; c++) begin
            @(negedge clk);
            if (accPrev) begin
                accCnt++;
                i++;
                if (i < 4) begin
                    reqWe = bWe[i]; reqAddr = bAddr[i]; reqWdata = bData[i]; reqBe = bBe[i];
                end else begin
                    reqValid = 1'b0;
                end
            end
            if (rspValid2) begin
                pulses++;
                if (!bWe[pulses-1]) checkVal("b2b_rdata", rdata2, expD[pulses-1]);
                if (ready2) viol++;
            end
            if (accCnt > pulses + 1) viol++;
            if (ready2 && accCnt != pulses) viol++;
            accPrev = ready2 && reqValid;
        end
        reqValid = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (rspValid2) pulses++;
        end
        checkVal("b2b_pulses", pulses, 4);
        checkVal("b2b_accepts", accCnt, 4);
        checkVal("b2b_overlap", viol, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] rd;
        int rspSeen;
        reset = 1'b0; reqValid = 1'b0; reqValid0 = 1'b0;
        reqWe = 1'b0; reqAddr = '0; reqWdata = '0; reqBe = '0;
        repeat (2) @(negedge clk);
        checkVal("rst_ready", ready2, 1'b0);
        checkVal("rst_valid", rspValid2, 1'b0);
        checkVal("rst_err", err2, 1'b0);
        checkVal("rst_rdata", rdata2, 32'h0);
        reset = 1'b1;
        #1 checkVal("ready_at_release", ready2, 1'b0);
        @(negedge clk);
        checkVal("ready_after_edge", ready2, 1'b1);

        for (int w = 0; w < 32; w++) issue(0, 1, 32'(w * 4), $urandom, 4'hF, rd);
        issue(0, 1, 32'((DEPTH - 1) * 4), $urandom, 4'hF, rd);

        // Write/read-back at 0x10.
        issue(0, 1, 32'h10, 32'hDEADBEEF, 4'hF, rd);
        issue(0, 0, 32'h10, 32'h0, 4'hF, rd);
        checkVal("rw_directed", rd, 32'hDEADBEEF);

        // Byte lanes at 0x20.
        issue(0, 1, 32'h20, 32'h11223344, 4'hF, rd);
        issue(0, 1, 32'h20, 32'hAABBCCDD, 4'b0101, rd);
        issue(0, 0, 32'h20, 32'h0, 4'hF, rd);
`ifdef MEM_BUS_CTRL_BYTE_EN_EN
        checkVal("byte_lanes", rd, 32'h11BB33DD);
        issue(0, 1, 32'h20, 32'h99999999, 4'b0000, rd);
        issue(0, 0, 32'h20, 32'h0, 4'hF, rd);
        checkVal("be_zero", rd, 32'h11BB33DD);
`else
        checkVal("byte_lanes", rd, 32'hAABBCCDD);
`endif

        // Faults: misaligned read and out-of-range write.
        issue(0, 0, 32'h12, 32'h0, 4'hF, rd);
        issue(0, 1, 32'(DEPTH * 4), 32'hCAFEF00D, 4'hF, rd);
        issue(0, 0, 32'((DEPTH - 1) * 4), 32'h0, 4'hF, rd);

        backToBack();

        // Reset during ACCESS of a write to 0x8.
        reqWe = 1'b1; reqAddr = 32'h8; reqWdata = 32'h55; reqBe = 4'hF; reqValid = 1'b1;
        @(negedge clk);
        reqValid = 1'b0;
        reset = 1'b0;
        rspSeen = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (rspValid2 || err2 || rdata2 != 0) rspSeen++;
        end
        checkVal("midrst_no_rsp", rspSeen, 0);
        reset = 1'b1;
        @(negedge clk);
        checkVal("midrst_ready", ready2, 1'b1);
        issue(0, 0, 32'h8, 32'h0, 4'hF, rd);

        // Randomized traffic.
        for (int n = 0; n < 80; n++) begin
            int r;
            logic [31:0] a;
            r = int'($urandom_range(0, 9));
            if (r == 0)      a = 32'($urandom_range(0, 31) * 4 + $urandom_range(1, 3));
            else if (r == 1) a = 32'((DEPTH + $urandom_range(0, 1000)) * 4);
            else             a = 32'($urandom_range(0, 31) * 4);
            issue(0, 1'($urandom), a, $urandom, 4'($urandom), rd);
        end

        // Zero-wait-state instance.
        issue(1, 1, 32'h40, 32'h0BADC0DE, 4'hF, rd);
        issue(1, 0, 32'h40, 32'h0, 4'hF, rd);
        checkVal("ws0_rdata", rd, 32'h0BADC0DE);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
